vote_capture: RTL and testbench

VOTE_CAPTURE -- requirements
Module: vote_capture

---
 rtl/vote_capture_if.sv | 35 +++
 rtl/vote_capture.sv | 110 +++++++++++
 tb/tb_vote_capture.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vote_capture_if.sv
// Purpose: groups the voting panel signals: mode, raw buttons, debounced
//          levels, per-candidate totals and the accepted-vote pulse.
// Ports:   master drives mode/buttons and observes results; slave is the design side.
interface vote_capture_if;
  logic       mode;
  logic       button0;
  logic       button1;
  logic       button2;
  logic       button3;
  logic       candidate_button_press0;
  logic       candidate_button_press1;
  logic       candidate_button_press2;
  logic       candidate_button_press3;
  logic [7:0] candidate_vote0;
  logic [7:0] candidate_vote1;
  logic [7:0] candidate_vote2;
  logic [7:0] candidate_vote3;
  logic       valid_vote_casted;

  modport master (
    output mode, button0, button1, button2, button3,
    input  candidate_button_press0, candidate_button_press1,
           candidate_button_press2, candidate_button_press3,
           candidate_vote0, candidate_vote1, candidate_vote2, candidate_vote3,
           valid_vote_casted
  );

  modport slave (
    input  mode, button0, button1, button2, button3,
    output candidate_button_press0, candidate_button_press1,
           candidate_button_press2, candidate_button_press3,
           candidate_vote0, candidate_vote1, candidate_vote2, candidate_vote3,
           valid_vote_casted
  );
endinterface

// File: rtl/vote_capture.sv
// Purpose: four-candidate vote capture; synchronizes and debounces raw buttons,
//          accepts one vote per single clean press, saturating 8-bit totals.
// Ports:   clock, reset (async active-high), bus (vote_capture_if.slave).
//          Latency raw edge -> valid_vote_casted: 2 + DEBOUNCE_CYCLES + 1 cycles.
module vote_capture #(
  parameter int DEBOUNCE_CYCLES = 10
) (
  input logic          clock,
  input logic          reset,
  vote_capture_if.slave bus
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [15:0] THRESH = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       deb;
  logic [3:0]       deb_copy;
  logic [3:0][15:0] stab_cnt;
  logic [3:0][7:0]  votes;
  logic [3:0]       press;
  logic             valid;
  logic             vote;
  state_t           state;
  state_t           state_next;

  assign raw = {bus.button3, bus.button2, bus.button1, bus.button0};

  // Two-flop synchronizer, then per-button stability counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_copy <= '0;
      stab_cnt <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_copy <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == THRESH) begin
          deb[i]      <= ~deb[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 16'd1;
        end
      end
    end
  end

  // A press event lasts exactly one cycle: the rising edge of the debounced level.
  assign press = deb & ~deb_copy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      votes <= '0;
    end else begin
      state <= state_next;
      valid <= vote;
      if (vote) begin
        for (int i = 0; i < 4; i++) begin
          if (press[i] && votes[i] != 8'hFF) begin
            votes[i] <= votes[i] + 8'd1;
          end
        end
      end
    end
  end

  // Any press in voting mode locks the panel; only a lone press counts.
  // LOCK releases only once every debounced button is back at 0, so a held
  // button can never produce a second vote and the pulse cannot repeat.
  always_comb begin
    state_next = state;
    vote       = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.mode && press != 4'b0000) begin
          state_next = LOCK;
          vote       = $onehot(press);
        end
      end
      LOCK: begin
        if (deb == 4'b0000) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.candidate_button_press0 = deb[0];
  assign bus.candidate_button_press1 = deb[1];
  assign bus.candidate_button_press2 = deb[2];
  assign bus.candidate_button_press3 = deb[3];
  assign bus.candidate_vote0         = votes[0];
  assign bus.candidate_vote1         = votes[1];
  assign bus.candidate_vote2         = votes[2];
  assign bus.candidate_vote3         = votes[3];
  assign bus.valid_vote_casted       = valid;

endmodule

// File: tb/tb_vote_capture.sv
// Purpose: directed self-checking bench for vote_capture with DEBOUNCE_CYCLES=4.
// Ports:   none; drives the interface master side, checks outputs 1 time unit
//          after each rising edge, counts pulses on the falling edge.
module tb_vote_capture;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   doubles = 0;
  logic prev_valid = 1'b0;
  int   p0;

  vote_capture_if vif ();

  vote_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif.slave)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (vif.valid_vote_casted) pulses <= pulses + 1;
    if (vif.valid_vote_casted && prev_valid) doubles <= doubles + 1;
    prev_valid <= vif.valid_vote_casted;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: vif.button0 = v;
      1: vif.button1 = v;
      2: vif.button2 = v;
      default: vif.button3 = v;
    endcase
  endtask

  task automatic press_btn(input int idx, input int hold);
    set_btn(idx, 1'b1);
    repeat (hold) step();
    set_btn(idx, 1'b0);
    repeat (10) step();
  endtask

  initial begin
    vif.mode = 1'b0;
    vif.button0 = 1'b0;
    vif.button1 = 1'b0;
    vif.button2 = 1'b0;
    vif.button3 = 1'b0;

    // Reset state, checked before the first clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_valid", 32'(vif.valid_vote_casted), 0);
    check("rst_vote2", 32'(vif.candidate_vote2), 0);
    check("rst_press2", 32'(vif.candidate_button_press2), 0);
    repeat (2) step();
    reset = 1'b0;
    step();

    // Clean press on button2: pulse exactly 7 cycles after the raw rise.
    vif.button2 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("lat_valid_k%0d", k), 32'(vif.valid_vote_casted), 32'(k == 7));
    end
    repeat (10) step();
    vif.button2 = 1'b0;
    repeat (10) step();
    check("clean_vote2", 32'(vif.candidate_vote2), 1);
    check("clean_vote0", 32'(vif.candidate_vote0), 0);
    check("clean_vote1", 32'(vif.candidate_vote1), 0);
    check("clean_vote3", 32'(vif.candidate_vote3), 0);

    // Bouncing button1: three 1-cycle glitches then a solid hold.
    p0 = pulses;
    for (int b = 0; b < 3; b++) begin
      vif.button1 = 1'b1; step();
      vif.button1 = 1'b0; step();
    end
    press_btn(1, 20);
    check("bounce_pulses", 32'(pulses - p0), 1);
    check("bounce_vote1", 32'(vif.candidate_vote1), 1);

    // Simultaneous button0 + button3: rejected, then a lone button3 counts.
    p0 = pulses;
    vif.button0 = 1'b1;
    vif.button3 = 1'b1;
    repeat (10) step();
    check("dual_press0", 32'(vif.candidate_button_press0), 1);
    check("dual_press3", 32'(vif.candidate_button_press3), 1);
    vif.button0 = 1'b0;
    vif.button3 = 1'b0;
    repeat (10) step();
    check("dual_pulses", 32'(pulses - p0), 0);
    check("dual_vote0", 32'(vif.candidate_vote0), 0);
    check("dual_vote3", 32'(vif.candidate_vote3), 0);
    press_btn(3, 8);
    check("after_dual_vote3", 32'(vif.candidate_vote3), 1);

    // button0 held while button1 is pressed and released.
    p0 = pulses;
    vif.button0 = 1'b1;
    repeat (8) step();
    press_btn(1, 8);
    vif.button0 = 1'b0;
    repeat (10) step();
    check("hold_pulses", 32'(pulses - p0), 1);
    check("hold_vote0", 32'(vif.candidate_vote0), 1);
    check("hold_vote1", 32'(vif.candidate_vote1), 1);

    // Saturation: bring candidate 2 from 1 up to 255, then one more press.
    for (int n = 0; n < 254; n++) press_btn(2, 8);
    check("sat_preload_vote2", 32'(vif.candidate_vote2), 255);
    p0 = pulses;
    press_btn(2, 8);
    check("sat_pulses", 32'(pulses - p0), 1);
    check("sat_vote2", 32'(vif.candidate_vote2), 255);

    // Result mode: debounced level follows, no vote, no pulse.
    vif.mode = 1'b1;
    p0 = pulses;
    vif.button1 = 1'b1;
    repeat (8) step();
    check("mode1_press1", 32'(vif.candidate_button_press1), 1);
    check("mode1_pulses", 32'(pulses - p0), 0);
    check("mode1_vote1", 32'(vif.candidate_vote1), 1);

    // Asynchronous reset mid-press clears everything before any edge.
    #1 reset = 1'b1;
    #1;
    check("arst_press1", 32'(vif.candidate_button_press1), 0);
    check("arst_vote2", 32'(vif.candidate_vote2), 0);
    check("arst_vote1", 32'(vif.candidate_vote1), 0);
    check("arst_valid", 32'(vif.valid_vote_casted), 0);

    // Button held through reset registers a vote once reset lifts.
    repeat (3) step();
    vif.mode = 1'b0;
    p0 = pulses;
    reset = 1'b0;
    repeat (10) step();
    check("held_pulses", 32'(pulses - p0), 1);
    check("held_vote1", 32'(vif.candidate_vote1), 1);
    check("held_vote0", 32'(vif.candidate_vote0), 0);
    vif.button1 = 1'b0;
    repeat (10) step();

    check("no_double_pulse", 32'(doubles), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
